// File: rtl/serial_byte_tx_pkg.sv
// Shared types and sizing helpers for the serial byte transmitter and its matching receiver.
// Default word/bit-period constants live here so both ends agree on the frame shape.
package serial_byte_tx_pkg;

   localparam int unsigned DefaultWidth = 8;
   localparam int unsigned DefaultDiv   = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StLatch = 2'd2
   } tx_state_e;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/serial_byte_tx_bit_timer.sv
// Bit-period timer: counts DIV cycles per bit and emits a registered tick on the
// terminal count. The run input describes the *next* cycle so that tick lines up with it.
module serial_byte_tx_bit_timer
   import serial_byte_tx_pkg::*;
#(
   parameter int unsigned DIV = DefaultDiv
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int unsigned CntW = (clog2(DIV) > 1) ? clog2(DIV) : 1;
   localparam logic [CntW-1:0] TermCnt = CntW'(DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            run_q;
   logic            tick_q, tick_d;

   // A run always starts at count 0; a finished period wraps to 0.
   always_comb begin
      cnt_d = '0;
      if (run && run_q && (cnt_q != TermCnt)) begin
         cnt_d = cnt_q + CntW'(1);
      end
      tick_d = run && (cnt_d == TermCnt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         run_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         run_q  <= run;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/serial_byte_tx.sv
// Parallel-in, serial-out transmitter with per-bit shift strobe and end-of-frame latch pulse.
// All outputs are flops, computed from next-state values so they align with the state they describe.
module serial_byte_tx
   import serial_byte_tx_pkg::*;
#(
   parameter int unsigned WIDTH     = DefaultWidth,
   parameter int unsigned DIV       = DefaultDiv,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             s_out,
   output logic             s_clk_en,
   output logic             s_latch,
   output logic             busy
);

   localparam int unsigned BitCntW = clog2(WIDTH + 1);
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(WIDTH - 1);

   tx_state_e            state_q, state_d;
   logic [WIDTH-1:0]     sr_q, sr_d;
   logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic                 tx_ready_q, tx_ready_d;
   logic                 s_out_q, s_out_d;
   logic                 s_latch_q, s_latch_d;
   logic                 busy_q, busy_d;
   logic                 strobe;
   logic                 timer_run;

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (tx_valid && tx_ready_q) begin
               sr_d      = tx_data;
               bit_cnt_d = '0;
               state_d   = StShift;
            end
         end
         StShift: begin
            // Zero fill means the register is empty again once the frame has gone out.
            if (strobe) begin
               sr_d      = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
               bit_cnt_d = bit_cnt_q + BitCntW'(1);
               if (bit_cnt_q == LastBit) begin
                  state_d = StLatch;
               end
            end
         end
         StLatch: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      tx_ready_d = (state_d == StIdle);
      busy_d     = (state_d != StIdle);
      s_latch_d  = (state_d == StLatch);
      s_out_d    = (state_d == StShift) && (LSB_FIRST ? sr_d[0] : sr_d[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         tx_ready_q <= 1'b1;
         s_out_q    <= 1'b0;
         s_latch_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_ready_q <= tx_ready_d;
         s_out_q    <= s_out_d;
         s_latch_q  <= s_latch_d;
         busy_q     <= busy_d;
      end
   end

   assign timer_run = (state_d == StShift);

   serial_byte_tx_bit_timer #(
      .DIV (DIV)
   ) u_bit_timer (
      .clk  (clk),
      .rst  (rst),
      .run  (timer_run),
      .tick (strobe)
   );

   assign tx_ready = tx_ready_q;
   assign s_out    = s_out_q;
   assign s_clk_en = strobe;
   assign s_latch  = s_latch_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Bench for serial_byte_tx: an LSB-first DIV=4 instance and an MSB-first DIV=1 instance,
// each looped back into a receiver model whose word is scored against a queue at s_latch.
module tb_serial_byte_tx;

   logic clk = 1'b0;
   logic rst;

   logic [7:0] tx_data_a, tx_data_b;
   logic tx_valid_a, tx_valid_b;
   logic tx_ready_a, s_out_a, s_clk_en_a, s_latch_a, busy_a;
   logic tx_ready_b, s_out_b, s_clk_en_b, s_latch_b, busy_b;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   logic [7:0] rx_a = 8'h00;
   logic [7:0] rx_b = 8'h00;
   int strb_a = 0, strb_b = 0;
   int latch_cnt_a = 0, latch_cnt_b = 0;

   always #5 clk = ~clk;

   serial_byte_tx #(
      .WIDTH     (8),
      .DIV       (4),
      .LSB_FIRST (1'b1)
   ) u_dut_a (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data_a),
      .tx_valid (tx_valid_a),
      .tx_ready (tx_ready_a),
      .s_out    (s_out_a),
      .s_clk_en (s_clk_en_a),
      .s_latch  (s_latch_a),
      .busy     (busy_a)
   );

   serial_byte_tx #(
      .WIDTH     (8),
      .DIV       (1),
      .LSB_FIRST (1'b0)
   ) u_dut_b (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data_b),
      .tx_valid (tx_valid_b),
      .tx_ready (tx_ready_b),
      .s_out    (s_out_b),
      .s_clk_en (s_clk_en_b),
      .s_latch  (s_latch_b),
      .busy     (busy_b)
   );

   // Right-shift receiver (serial in at MSB) for the LSB-first instance.
   always @(negedge clk) begin
      if (rst) begin
         strb_a = 0;
         rx_a   = 8'h00;
      end else begin
         if (s_clk_en_a) begin
            rx_a   = {s_out_a, rx_a[7:1]};
            strb_a = strb_a + 1;
         end
         if (s_latch_a) begin
            logic [7:0] e;
            latch_cnt_a = latch_cnt_a + 1;
            n_checks = n_checks + 1;
            if (exp_a.size() == 0) begin
               n_fail = n_fail + 1;
               $display("FAIL rx_a_unexpected_latch: got word %02h, required no latch", rx_a);
            end else begin
               e = exp_a.pop_front();
               if (rx_a !== e) begin
                  n_fail = n_fail + 1;
                  $display("FAIL rx_a_word: got %02h, required %02h", rx_a, e);
               end
            end
            n_checks = n_checks + 1;
            if (strb_a !== 8 || s_clk_en_a !== 1'b0) begin
               n_fail = n_fail + 1;
               $display("FAIL rx_a_strobes: got %0d strobes (s_clk_en=%0b at latch), required 8 (0)",
                        strb_a, s_clk_en_a);
            end
            strb_a = 0;
         end
      end
   end

   // Left-shift receiver (serial in at LSB) for the MSB-first instance.
   always @(negedge clk) begin
      if (rst) begin
         strb_b = 0;
         rx_b   = 8'h00;
      end else begin
         if (s_clk_en_b) begin
            rx_b   = {rx_b[6:0], s_out_b};
            strb_b = strb_b + 1;
         end
         if (s_latch_b) begin
            logic [7:0] e;
            latch_cnt_b = latch_cnt_b + 1;
            n_checks = n_checks + 1;
            if (exp_b.size() == 0) begin
               n_fail = n_fail + 1;
               $display("FAIL rx_b_unexpected_latch: got word %02h, required no latch", rx_b);
            end else begin
               e = exp_b.pop_front();
               if (rx_b !== e || strb_b !== 8) begin
                  n_fail = n_fail + 1;
                  $display("FAIL rx_b_word: got %02h after %0d strobes, required %02h after 8",
                           rx_b, strb_b, e);
               end
            end
            strb_b = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required test completion");
      $fatal(1, "timeout");
   end

   task automatic send(input int sel, input logic [7:0] w);
      int k;
      logic rdy;
      @(negedge clk);
      if (sel == 0) begin
         tx_valid_a = 1'b1;
         tx_data_a  = w;
      end else begin
         tx_valid_b = 1'b1;
         tx_data_b  = w;
      end
      k   = 0;
      rdy = (sel == 0) ? tx_ready_a : tx_ready_b;
      while (!rdy && k < 200) begin
         @(negedge clk);
         k++;
         rdy = (sel == 0) ? tx_ready_a : tx_ready_b;
      end
      n_checks++;
      if (!rdy) begin
         n_fail++;
         $display("FAIL send_ready(dut %0d): tx_ready=%0b after %0d cycles, required 1", sel, rdy, k);
      end
      @(posedge clk);
      if (rdy) begin
         if (sel == 0) exp_a.push_back(w);
         else exp_b.push_back(w);
      end
      #1;
      tx_valid_a = 1'b0;
      tx_valid_b = 1'b0;
   endtask

   task automatic wait_idle(input int sel);
      int k;
      logic b;
      k = 0;
      do begin
         @(negedge clk);
         k++;
         b = (sel == 0) ? busy_a : busy_b;
      end while (b && k < 100);
      n_checks++;
      if (b) begin
         n_fail++;
         $display("FAIL wait_idle(dut %0d): busy=%0b after %0d cycles, required 0", sel, b, k);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      tx_valid_a = 1'b1;
      tx_data_a  = 8'hFF;
      tx_valid_b = 1'b1;
      tx_data_b  = 8'hFF;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({tx_ready_a, s_out_a, s_clk_en_a, s_latch_a, busy_a} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_a: got rdy/out/en/latch/busy=%05b, required 10000",
                  {tx_ready_a, s_out_a, s_clk_en_a, s_latch_a, busy_a});
      end
      n_checks++;
      if ({tx_ready_b, s_out_b, s_clk_en_b, s_latch_b, busy_b} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_b: got rdy/out/en/latch/busy=%05b, required 10000",
                  {tx_ready_b, s_out_b, s_clk_en_b, s_latch_b, busy_b});
      end
      tx_valid_a = 1'b0;
      tx_valid_b = 1'b0;
      rst        = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0 || tx_ready_a !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_no_accept: got busy_a=%0b busy_b=%0b tx_ready_a=%0b, required 0 0 1",
                  busy_a, busy_b, tx_ready_a);
      end
   endtask

   task automatic test_frame_a5();
      logic [7:0] w;
      logic e_out, e_en, e_latch, e_rdy, e_busy;
      w = 8'hA5;
      send(0, w);
      for (int cyc = 1; cyc <= 34; cyc++) begin
         @(negedge clk);
         e_out   = (cyc <= 32) ? w[(cyc - 1) / 4] : 1'b0;
         e_en    = (cyc <= 32) && (cyc % 4 == 0);
         e_latch = (cyc == 33);
         e_rdy   = (cyc == 34);
         e_busy  = (cyc <= 33);
         n_checks++;
         if ({s_out_a, s_clk_en_a, s_latch_a, tx_ready_a, busy_a} !==
             {e_out, e_en, e_latch, e_rdy, e_busy}) begin
            n_fail++;
            $display("FAIL frame_a5 cycle %0d: got out/en/latch/rdy/busy=%05b, required %05b", cyc,
                     {s_out_a, s_clk_en_a, s_latch_a, tx_ready_a, busy_a},
                     {e_out, e_en, e_latch, e_rdy, e_busy});
         end
      end
   endtask

   task automatic test_loopback();
      int base;
      base = latch_cnt_a;
      send(0, 8'h3C);
      wait_idle(0);
      send(0, 8'hFF);
      wait_idle(0);
      n_checks++;
      if (latch_cnt_a !== base + 2 || exp_a.size() != 0) begin
         n_fail++;
         $display("FAIL loopback_frames: got %0d latches (%0d pending), required 2 (0)",
                  latch_cnt_a - base, exp_a.size());
      end
   endtask

   task automatic test_back_to_back();
      int base;
      int k;
      base = latch_cnt_a;
      @(negedge clk);
      tx_valid_a = 1'b1;
      tx_data_a  = 8'h01;
      @(posedge clk);
      exp_a.push_back(8'h01);
      #1 tx_data_a = 8'h02;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!tx_ready_a && k < 100);
      n_checks++;
      if (k !== 34) begin
         n_fail++;
         $display("FAIL back_to_back_accept: got second accept at cycle %0d, required 34", k);
      end
      @(posedge clk);
      exp_a.push_back(8'h02);
      #1 tx_valid_a = 1'b0;
      for (int p = 0; p < 3; p++) begin
         repeat (4) @(negedge clk);
         tx_valid_a = 1'b1;
         tx_data_a  = 8'h77;
         @(negedge clk);
         tx_valid_a = 1'b0;
      end
      wait_idle(0);
      repeat (40) @(negedge clk);
      n_checks++;
      if (latch_cnt_a !== base + 2 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL back_to_back_frames: got %0d frames busy=%0b, required 2 frames busy=0",
                  latch_cnt_a - base, busy_a);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      int s;
      int k;
      base = latch_cnt_a;
      send(0, 8'h5A);
      s = 0;
      k = 0;
      while (s < 3 && k < 100) begin
         @(negedge clk);
         k++;
         if (s_clk_en_a) s++;
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({tx_ready_a, s_out_a, s_clk_en_a, s_latch_a, busy_a} !== 5'b10000 || k !== 12) begin
         n_fail++;
         $display("FAIL reset_mid: got rdy/out/en/latch/busy=%05b (3rd strobe at %0d), req 10000 (12)",
                  {tx_ready_a, s_out_a, s_clk_en_a, s_latch_a, busy_a}, k);
      end
      #1;
      rst = 1'b0;
      exp_a.delete();
      repeat (40) @(negedge clk);
      n_checks++;
      if (latch_cnt_a !== base) begin
         n_fail++;
         $display("FAIL reset_mid_no_latch: got %0d latches, required 0", latch_cnt_a - base);
      end
      send(0, 8'hC3);
      wait_idle(0);
      n_checks++;
      if (latch_cnt_a !== base + 1) begin
         n_fail++;
         $display("FAIL reset_mid_resume: got %0d latches, required 1", latch_cnt_a - base);
      end
   endtask

   task automatic test_div1_msb();
      logic [7:0] w;
      logic e_out, e_en, e_latch, e_rdy;
      w = 8'h80;
      send(1, w);
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         e_out   = (cyc <= 8) ? w[8 - cyc] : 1'b0;
         e_en    = (cyc <= 8);
         e_latch = (cyc == 9);
         e_rdy   = (cyc == 10);
         n_checks++;
         if ({s_out_b, s_clk_en_b, s_latch_b, tx_ready_b} !== {e_out, e_en, e_latch, e_rdy}) begin
            n_fail++;
            $display("FAIL div1_msb cycle %0d: got out/en/latch/rdy=%04b, required %04b", cyc,
                     {s_out_b, s_clk_en_b, s_latch_b, tx_ready_b}, {e_out, e_en, e_latch, e_rdy});
         end
      end
      send(1, 8'h3B);
      wait_idle(1);
      n_checks++;
      if (latch_cnt_b !== 2 || exp_b.size() != 0) begin
         n_fail++;
         $display("FAIL div1_frames: got %0d latches (%0d pending), required 2 (0)",
                  latch_cnt_b, exp_b.size());
      end
   endtask

   initial begin
      rst        = 1'b1;
      tx_valid_a = 1'b0;
      tx_valid_b = 1'b0;
      tx_data_a  = 8'h00;
      tx_data_b  = 8'h00;
      test_reset();
      test_frame_a5();
      test_loopback();
      test_back_to_back();
      test_reset_mid();
      test_div1_msb();
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
